alu_arbiter: RTL
================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 32-bit combinational ALU (`ALU32`). It accepts operations over valid/ready request ports, drives the ALU operand and control inputs from registers, and waits a programmable number of settle cycles. It then captures `result`/`zero` and returns them on a single tagged response channel. It sits between the board-level operand sources (switch front end, test sequencer) and the `ALU32` instance, replacing the direct wiring used in the top level.

## Interface
- `WIDTH`, 32: operand/result width; must match `ALU32`.
- `EXEC_CYCLES`, 1: clock cycles the operands are held on the ALU before capture; legal range 1..15.
- `clk` in 1: system clock (100 MHz board clock).
- `rst_n` in 1: asynchronous, active-low reset; one clock domain only.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 handshake accepted this cycle.
- `req0_a`, `req0_b` in WIDTH each: requester 0 operands.
- `req0_ctr` in 4: requester 0 ALU control code.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_ctr`: same as requester 0, for requester 1.
- `alu_a`, `alu_b` out WIDTH: registered operands to the ALU.
- `alu_ctr` out 4: registered control code to the ALU.
- `alu_result` in WIDTH: ALU result, combinational from `alu_*`.
- `alu_zero` in 1: ALU zero flag.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: index of the requester that owns the response.
- `rsp_result` out WIDTH: captured result.
- `rsp_zero` out 1: captured zero flag.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Arbitrate among asserted `reqN_valid` using round-robin. The requester other than `last_grant` wins ties.
  - Only the winner sees `reqN_ready`=1. It is combinational from the state, the valids and `last_grant`, and never depends on `rsp_ready`.
  - On `valid & ready`:
    - Latch that requester's a/b/ctr into `alu_a/alu_b/alu_ctr`.
    - Latch its index into `rsp_id` and `last_grant`.
    - Load `cnt` = EXEC_CYCLES-1 and go to EXEC.
  - No valids: stay in IDLE, both readys 0.
- **EXEC**
  - Both readys are 0 and `alu_*` is held stable.
  - If `cnt`≠0, decrement it.
  - If `cnt`==0, register `alu_result`→`rsp_result` and `alu_zero`→`rsp_zero`, set `rsp_valid`, and go to RESP.
- **RESP**
  - `rsp_*` and `alu_*` are held stable and both readys are 0.
  - On `rsp_valid & rsp_ready`: clear `rsp_valid` and go to IDLE.
  - `rsp_ready` low: hold the response indefinitely.
- `alu_*` keep their last values in IDLE; they are not cleared after an operation.
- Values at the moment a request is accepted are the only ones used. Later changes to `reqN_a/b/ctr` have no effect.
- Widths: all data paths are WIDTH bits with no extension or truncation. `cnt` is 4 bits.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - state=IDLE, `cnt`=0, `last_grant`=1 (so req0 wins the first tie).
  - `alu_a`/`alu_b`=0, `alu_ctr`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0, `busy`=0.
  - `req0_ready`/`req1_ready` are 0 while `rst_n`=0.
- Per-operation timeline, with accept at cycle T:
  - `alu_*` are valid from T+1.
  - EXEC occupies T+1..T+EXEC_CYCLES.
  - `rsp_valid` rises at T+EXEC_CYCLES+1.
- If `rsp_ready` is already high, the response handshake is at T+E+1 and the next accept can happen no earlier than T+E+2. Minimum initiation interval is EXEC_CYCLES+2.
- Simultaneous valids in IDLE produce exactly one grant. The loser keeps valid high and is granted in the next IDLE.
- Reset mid-operation (EXEC or RESP) discards the in-flight operation. No response is produced after reset release.
- `rst_n` deassertion has no synchronizer inside this block; the system reset generator provides one.

## Test plan
Benches use an ALU stub: `alu_result` = `alu_a`+`alu_b`, `alu_zero` = (sum==0).

1. **Single request.** Reset, then req0 a=32'h5, b=32'h3, ctr=4'h0, `rsp_ready`=1, EXEC_CYCLES=1. Required: accept at T, `rsp_valid` at T+2 with `rsp_result`=32'h8, `rsp_zero`=0, `rsp_id`=0, and `busy` high T+1..T+2.
2. **Tie after reset.** Both valid from reset release. Required: req0 granted first, then req1, then req0 (alternating), with `rsp_id` sequence 0,1,0.
3. **Response backpressure.** Hold `rsp_ready`=0 for 5 cycles after `rsp_valid`. Required: `rsp_*` and `alu_*` constant, both readys 0; handshake on the cycle `rsp_ready` rises and IDLE the cycle after.
4. **Settle count and zero flag.** EXEC_CYCLES=4 with a=32'hFFFFFFFF, b=32'h1. Required: `rsp_valid` at T+5 with `rsp_result`=0 and `rsp_zero`=1. Changing `req0_a` after T has no effect on the result.
5. **Reset mid-operation.** Assert `rst_n`=0 during EXEC. Required: all outputs take their reset values immediately, and no `rsp_valid` pulse follows release.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response bundle for alu_arbiter.
// slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [3:0]       req0_ctr;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       req1_ctr;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_ctr;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctr,
    input  req1_valid, req1_a, req1_b, req1_ctr,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_ctr,
    output rsp_valid, rsp_id, rsp_result, rsp_zero,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctr,
    output req1_valid, req1_a, req1_b, req1_ctr,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_ctr,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin sequencer for a shared ALU.
// Ports: clk, rst_n (async, active low), bus (alu_arbiter_if.slave).
module alu_arbiter #(
  parameter int WIDTH       = 32,
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic             r_last;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_ctr;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero;

  logic w_idle;
  logic w_pick1;
  logic w_rdy0;
  logic w_rdy1;

  // rst_n gates the readys so nothing handshakes during reset.
  assign w_idle  = rst_n && (r_state == S_IDLE);
  // req1 wins when alone, or on a tie when req0 was granted last.
  assign w_pick1 = bus.req1_valid &&
                   (!bus.req0_valid || !r_last);
  assign w_rdy1  = w_idle && w_pick1;
  assign w_rdy0  = w_idle && bus.req0_valid && !w_pick1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last       <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctr    <= 4'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_rdy0 || w_rdy1) begin
            r_alu_a   <= w_rdy1 ? bus.req1_a : bus.req0_a;
            r_alu_b   <= w_rdy1 ? bus.req1_b : bus.req0_b;
            r_alu_ctr <= w_rdy1 ? bus.req1_ctr
                                : bus.req0_ctr;
            r_rsp_id  <= w_rdy1;
            r_last    <= w_rdy1;
            r_cnt     <= CNT_INIT;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_result <= bus.alu_result;
            r_rsp_zero   <= bus.alu_zero;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_ctr    = r_alu_ctr;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;
  assign bus.busy       = (r_state != S_IDLE);
endmodule
